// File: rtl/ras_req_gen_if.sv
// ras_req_gen_if
// Bundles every signal of ras_req_gen except clk/reset:
//   - fetch side:  flush, in_valid/in_ready, in_pc, in_instr0/1, in_slot1_valid
//   - stack side:  ras_push/ras_pop, ras_ret_pc_push, ras_flush, ras_ret_pc_pop, ras_fail
//   - record side: out_valid/out_ready, out_pc, out_kind, out_slot,
//                  out_target, out_target_valid
// Modport "slave" is the request generator itself.
// Modport "master" is its environment: fetch, stack and next-PC selector.
interface ras_req_gen_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_instr0;
    logic [31:0] in_instr1;
    logic        in_slot1_valid;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_ret_pc_push;
    logic        ras_flush;
    logic [31:0] ras_ret_pc_pop;
    logic        ras_fail;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [1:0]  out_kind;
    logic        out_slot;
    logic [31:0] out_target;
    logic        out_target_valid;

    modport master (
        output flush, in_valid, in_pc, in_instr0, in_instr1, in_slot1_valid,
               ras_ret_pc_pop, ras_fail, out_ready,
        input  in_ready, ras_push, ras_pop, ras_ret_pc_push, ras_flush,
               out_valid, out_pc, out_kind, out_slot, out_target, out_target_valid
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr0, in_instr1, in_slot1_valid,
               ras_ret_pc_pop, ras_fail, out_ready,
        output in_ready, ras_push, ras_pop, ras_ret_pc_push, ras_flush,
               out_valid, out_pc, out_kind, out_slot, out_target, out_target_valid
    );
endinterface

// File: rtl/ras_req_gen.sv
// ras_req_gen
// Pre-decodes MIPS calls (JAL, JALR rd=$31) and returns (JR $31) in
// two-instruction fetch bundles. Delay slots are honoured.
// For each qualifying bundle it issues one push or one pop to the return
// address stack. It then forwards a registered prediction record downstream.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   bus   - ras_req_gen_if.slave (fetch input, stack requests, prediction record)
// Pipeline: stage S holds the accepted bundle and its decoded op.
// Stage O holds the outgoing record.
// The stack op is issued in the cycle S moves into O.
module ras_req_gen (
    input  logic         clk,
    input  logic         reset,
    ras_req_gen_if.slave bus
);

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_CALL = 2'b01;
    localparam logic [1:0] KIND_RET  = 2'b10;

    // JAL, or JALR writing the link register $31
    function automatic logic is_call(input logic [31:0] instr);
        logic jal;
        logic jalr;
        jal  = (instr[31:26] == 6'b000011);
        jalr = (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b001001) &&
               (instr[15:11] == 5'd31);
        return jal | jalr;
    endfunction

    // JR through the link register $31
    function automatic logic is_ret(input logic [31:0] instr);
        return (instr[31:26] == 6'b000000) && (instr[5:0] == 6'b001000) &&
               (instr[25:21] == 5'd31);
    endfunction

    logic        s_valid_q;
    logic [31:0] s_pc_q;
    logic [1:0]  s_kind_q;
    logic        s_slot_q;
    logic        delay_pending_q;

    logic        out_valid_q;
    logic [31:0] out_pc_q;
    logic [1:0]  out_kind_q;
    logic        out_slot_q;
    logic [31:0] out_target_q;
    logic        out_target_valid_q;

    logic        call0_s;
    logic        ret0_s;
    logic        op0_s;
    logic        call1_s;
    logic        ret1_s;
    logic        op1_s;
    logic [1:0]  kind_d;
    logic        slot_d;
    logic        pend_d;
    logic        advance_s;
    logic        accept_s;

    // Decode the incoming bundle. Slot 0 is skipped when it is the delay
    // slot of the previous bundle's op. Slot 1 is skipped when slot 0 owns it.
    always_comb begin
        call0_s = 1'b0;
        ret0_s  = 1'b0;
        call1_s = 1'b0;
        ret1_s  = 1'b0;
        kind_d  = KIND_NONE;
        if (!delay_pending_q) begin
            call0_s = is_call(bus.in_instr0);
            ret0_s  = is_ret(bus.in_instr0);
        end else begin
            call0_s = 1'b0;
            ret0_s  = 1'b0;
        end
        op0_s = call0_s | ret0_s;
        if (!op0_s && bus.in_slot1_valid) begin
            call1_s = is_call(bus.in_instr1);
            ret1_s  = is_ret(bus.in_instr1);
        end else begin
            call1_s = 1'b0;
            ret1_s  = 1'b0;
        end
        op1_s = call1_s | ret1_s;
        if (call0_s || call1_s) begin
            kind_d = KIND_CALL;
        end else if (ret0_s || ret1_s) begin
            kind_d = KIND_RET;
        end else begin
            kind_d = KIND_NONE;
        end
        slot_d = op1_s;
        // The delay slot lands in the next bundle when the op sits in slot 1,
        // or when the op sits in slot 0 and slot 1 is empty.
        pend_d = op1_s | (op0_s & ~bus.in_slot1_valid);
    end

    assign advance_s = s_valid_q & (~out_valid_q | bus.out_ready);
    assign accept_s  = bus.in_valid & bus.in_ready & ~bus.flush;

    assign bus.in_ready        = ~s_valid_q | advance_s;
    assign bus.ras_flush       = bus.flush;
    // A stack op fires only on the cycle S advances, so each op is issued once.
    assign bus.ras_push        = advance_s & ~bus.flush & ~reset & (s_kind_q == KIND_CALL);
    assign bus.ras_pop         = advance_s & ~bus.flush & ~reset & (s_kind_q == KIND_RET);
    assign bus.ras_ret_pc_push = s_pc_q + (s_slot_q ? 32'd12 : 32'd8);

    assign bus.out_valid        = out_valid_q;
    assign bus.out_pc           = out_pc_q;
    assign bus.out_kind         = out_kind_q;
    assign bus.out_slot         = out_slot_q;
    assign bus.out_target       = out_target_q;
    assign bus.out_target_valid = out_target_valid_q;

    // Stage S, delay-slot tracking and stage O; reset and flush squash everything.
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            s_valid_q          <= 1'b0;
            s_pc_q             <= 32'd0;
            s_kind_q           <= KIND_NONE;
            s_slot_q           <= 1'b0;
            delay_pending_q    <= 1'b0;
            out_valid_q        <= 1'b0;
            out_pc_q           <= 32'd0;
            out_kind_q         <= KIND_NONE;
            out_slot_q         <= 1'b0;
            out_target_q       <= 32'd0;
            out_target_valid_q <= 1'b0;
        end else begin
            if (accept_s) begin
                s_valid_q       <= 1'b1;
                s_pc_q          <= bus.in_pc;
                s_kind_q        <= kind_d;
                s_slot_q        <= slot_d;
                delay_pending_q <= pend_d;
            end else if (advance_s) begin
                s_valid_q <= 1'b0;
            end else begin
                s_valid_q <= s_valid_q;
            end

            if (advance_s) begin
                out_valid_q <= 1'b1;
                out_pc_q    <= s_pc_q;
                out_kind_q  <= s_kind_q;
                out_slot_q  <= s_slot_q;
                // The popped address is sampled in the same cycle as the pop.
                if (s_kind_q == KIND_RET) begin
                    out_target_q       <= bus.ras_ret_pc_pop;
                    out_target_valid_q <= ~bus.ras_fail;
                end else begin
                    out_target_q       <= 32'd0;
                    out_target_valid_q <= 1'b0;
                end
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end else begin
                out_valid_q <= out_valid_q;
            end
        end
    end

endmodule

// File: tb/tb_ras_req_gen.sv
module tb_ras_req_gen;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] JAL    = 32'h0C00_0400;
    localparam logic [31:0] JR31   = 32'h03E0_0008;
    localparam logic [31:0] JR4    = 32'h0080_0008;
    localparam logic [31:0] JALR31 = 32'h0000_F809;
    localparam logic [31:0] JALR5  = 32'h0000_2809;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    ras_req_gen_if bus ();

    ras_req_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] i0,
                         input logic [31:0] i1, input logic s1v);
        bus.in_valid       = 1'b1;
        bus.in_pc          = pc;
        bus.in_instr0      = i0;
        bus.in_instr1      = i1;
        bus.in_slot1_valid = s1v;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        if (bus.out_valid !== 1'b0) begin $display("FAIL rst_out_valid act=%0h exp=0", bus.out_valid); n_bad++; end n_cmp++;
        if (bus.out_kind !== 2'b00) begin $display("FAIL rst_out_kind act=%0h exp=0", bus.out_kind); n_bad++; end n_cmp++;
        if (bus.out_pc !== 32'd0) begin $display("FAIL rst_out_pc act=%0h exp=0", bus.out_pc); n_bad++; end n_cmp++;
        if (bus.out_slot !== 1'b0) begin $display("FAIL rst_out_slot act=%0h exp=0", bus.out_slot); n_bad++; end n_cmp++;
        if (bus.out_target !== 32'd0) begin $display("FAIL rst_out_target act=%0h exp=0", bus.out_target); n_bad++; end n_cmp++;
        if (bus.out_target_valid !== 1'b0) begin $display("FAIL rst_tv act=%0h exp=0", bus.out_target_valid); n_bad++; end n_cmp++;
        if (bus.in_ready !== 1'b1) begin $display("FAIL rst_in_ready act=%0h exp=1", bus.in_ready); n_bad++; end n_cmp++;
        if ({bus.ras_push, bus.ras_pop} !== 2'b00) begin $display("FAIL rst_ras_ops act=%0b exp=00", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
    endtask

    task automatic test_call();
        bus.out_ready = 1'b1;
        offer(32'h0000_1000, JAL, NOP, 1'b1);
        #1;
        if (bus.in_ready !== 1'b1) begin $display("FAIL call_in_ready act=%0h exp=1", bus.in_ready); n_bad++; end n_cmp++;
        tick();
        bus.in_valid = 1'b0;
        #1;
        if ({bus.ras_push, bus.ras_pop} !== 2'b10) begin $display("FAIL call_ops act=%0b exp=10", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        if (bus.ras_ret_pc_push !== 32'h0000_1008) begin $display("FAIL call_push_pc act=%0h exp=1008", bus.ras_ret_pc_push); n_bad++; end n_cmp++;
        if (bus.ras_flush !== 1'b0) begin $display("FAIL call_ras_flush act=%0h exp=0", bus.ras_flush); n_bad++; end n_cmp++;
        tick();
        if (bus.out_valid !== 1'b1) begin $display("FAIL call_out_valid act=%0h exp=1", bus.out_valid); n_bad++; end n_cmp++;
        if ({bus.out_kind, bus.out_slot} !== 3'b010) begin $display("FAIL call_kind_slot act=%0b exp=010", {bus.out_kind, bus.out_slot}); n_bad++; end n_cmp++;
        if (bus.out_pc !== 32'h0000_1000) begin $display("FAIL call_out_pc act=%0h exp=1000", bus.out_pc); n_bad++; end n_cmp++;
        if ({bus.out_target_valid, bus.out_target} !== 33'd0) begin $display("FAIL call_target act=%0h exp=0", {bus.out_target_valid, bus.out_target}); n_bad++; end n_cmp++;
        if (bus.ras_push !== 1'b0) begin $display("FAIL call_push_once act=%0h exp=0", bus.ras_push); n_bad++; end n_cmp++;
        tick();
        if (bus.out_valid !== 1'b0) begin $display("FAIL call_drain act=%0h exp=0", bus.out_valid); n_bad++; end n_cmp++;
    endtask

    task automatic test_return();
        bus.ras_ret_pc_pop = 32'h0000_1008;
        bus.ras_fail       = 1'b0;
        offer(32'h0000_2000, NOP, JR31, 1'b1);
        tick();
        // This JAL is the delay slot of the JR in the previous bundle.
        offer(32'h0000_2008, JAL, NOP, 1'b1);
        #1;
        if ({bus.ras_push, bus.ras_pop} !== 2'b01) begin $display("FAIL ret_ops act=%0b exp=01", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        if (bus.in_ready !== 1'b1) begin $display("FAIL ret_in_ready act=%0h exp=1", bus.in_ready); n_bad++; end n_cmp++;
        tick();
        bus.in_valid = 1'b0;
        #1;
        if ({bus.ras_push, bus.ras_pop} !== 2'b00) begin $display("FAIL ret_delay_slot_ops act=%0b exp=00", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        if ({bus.out_kind, bus.out_slot} !== 3'b101) begin $display("FAIL ret_kind_slot act=%0b exp=101", {bus.out_kind, bus.out_slot}); n_bad++; end n_cmp++;
        if (bus.out_pc !== 32'h0000_2000) begin $display("FAIL ret_out_pc act=%0h exp=2000", bus.out_pc); n_bad++; end n_cmp++;
        if (bus.out_target !== 32'h0000_1008) begin $display("FAIL ret_target act=%0h exp=1008", bus.out_target); n_bad++; end n_cmp++;
        if (bus.out_target_valid !== 1'b1) begin $display("FAIL ret_tv act=%0h exp=1", bus.out_target_valid); n_bad++; end n_cmp++;
        tick();
        if ({bus.out_valid, bus.out_kind} !== 3'b100) begin $display("FAIL ret_next_kind act=%0b exp=100", {bus.out_valid, bus.out_kind}); n_bad++; end n_cmp++;
        if (bus.out_pc !== 32'h0000_2008) begin $display("FAIL ret_next_pc act=%0h exp=2008", bus.out_pc); n_bad++; end n_cmp++;
        tick();
    endtask

    task automatic test_ret_fail();
        bus.ras_ret_pc_pop = 32'hDEAD_BEEF;
        bus.ras_fail       = 1'b1;
        // Slot 1 JAL is the delay slot of the slot 0 JR.
        offer(32'h0000_3000, JR31, JAL, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        if ({bus.ras_push, bus.ras_pop} !== 2'b01) begin $display("FAIL fail_ops act=%0b exp=01", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        tick();
        if ({bus.out_valid, bus.out_kind, bus.out_slot} !== 4'b1100) begin $display("FAIL fail_kind act=%0b exp=1100", {bus.out_valid, bus.out_kind, bus.out_slot}); n_bad++; end n_cmp++;
        if (bus.out_target_valid !== 1'b0) begin $display("FAIL fail_tv act=%0h exp=0", bus.out_target_valid); n_bad++; end n_cmp++;
        if (bus.out_target !== 32'hDEAD_BEEF) begin $display("FAIL fail_target act=%0h exp=deadbeef", bus.out_target); n_bad++; end n_cmp++;
        if ({bus.ras_push, bus.ras_pop} !== 2'b00) begin $display("FAIL fail_after_ops act=%0b exp=00", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        bus.ras_fail = 1'b0;
        tick();
    endtask

    task automatic test_no_op();
        offer(32'h0000_4100, JALR5, JR4, 1'b1);
        tick();
        offer(32'h0000_4200, JAL, JR31, 1'b1);
        #1;
        if ({bus.ras_push, bus.ras_pop} !== 2'b00) begin $display("FAIL noop_ops act=%0b exp=00", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        tick();
        bus.in_valid = 1'b0;
        #1;
        if ({bus.out_valid, bus.out_kind} !== 3'b100) begin $display("FAIL noop_kind act=%0b exp=100", {bus.out_valid, bus.out_kind}); n_bad++; end n_cmp++;
        if ({bus.ras_push, bus.ras_pop} !== 2'b10) begin $display("FAIL both_ops act=%0b exp=10", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        if (bus.ras_ret_pc_push !== 32'h0000_4208) begin $display("FAIL both_push_pc act=%0h exp=4208", bus.ras_ret_pc_push); n_bad++; end n_cmp++;
        tick();
        if ({bus.out_kind, bus.out_slot} !== 3'b010) begin $display("FAIL both_kind_slot act=%0b exp=010", {bus.out_kind, bus.out_slot}); n_bad++; end n_cmp++;
        tick();
    endtask

    task automatic test_jalr_wrap();
        offer(32'hFFFF_FFF8, NOP, JALR31, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        if (bus.ras_push !== 1'b1) begin $display("FAIL jalr_push act=%0h exp=1", bus.ras_push); n_bad++; end n_cmp++;
        if (bus.ras_ret_pc_push !== 32'h0000_0004) begin $display("FAIL jalr_wrap_pc act=%0h exp=4", bus.ras_ret_pc_push); n_bad++; end n_cmp++;
        tick();
        if ({bus.out_kind, bus.out_slot} !== 3'b011) begin $display("FAIL jalr_kind_slot act=%0b exp=011", {bus.out_kind, bus.out_slot}); n_bad++; end n_cmp++;
        if (bus.out_pc !== 32'hFFFF_FFF8) begin $display("FAIL jalr_out_pc act=%0h exp=fffffff8", bus.out_pc); n_bad++; end n_cmp++;
        // The slot 0 JAL is the delay slot of the JALR, so it is not decoded.
        offer(32'h0000_0100, JAL, NOP, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        if (bus.ras_push !== 1'b0) begin $display("FAIL jalr_delay_push act=%0h exp=0", bus.ras_push); n_bad++; end n_cmp++;
        tick();
        tick();
    endtask

    task automatic test_back_to_back_stall();
        bus.ras_ret_pc_pop = 32'h1234_5678;
        bus.ras_fail       = 1'b0;
        bus.out_ready      = 1'b0;
        offer(32'h0000_5000, JAL, NOP, 1'b1);
        tick();
        offer(32'h0000_5100, NOP, JR31, 1'b1);
        #1;
        if ({bus.ras_push, bus.ras_pop} !== 2'b10) begin $display("FAIL bp_first_ops act=%0b exp=10", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        tick();
        offer(32'h0000_5200, NOP, NOP, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            if ({bus.ras_push, bus.ras_pop, bus.in_ready} !== 3'b000) begin $display("FAIL bp_stall_%0d act=%0b exp=000", k, {bus.ras_push, bus.ras_pop, bus.in_ready}); n_bad++; end n_cmp++;
            if ({bus.out_valid, bus.out_kind, bus.out_pc} !== {1'b1, 2'b01, 32'h0000_5000}) begin $display("FAIL bp_hold_%0d act=%0h exp=%0h", k, {bus.out_valid, bus.out_kind, bus.out_pc}, {1'b1, 2'b01, 32'h0000_5000}); n_bad++; end n_cmp++;
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        if ({bus.ras_push, bus.ras_pop, bus.in_ready} !== 3'b011) begin $display("FAIL bp_release act=%0b exp=011", {bus.ras_push, bus.ras_pop, bus.in_ready}); n_bad++; end n_cmp++;
        tick();
        bus.in_valid = 1'b0;
        #1;
        if ({bus.out_kind, bus.out_slot, bus.out_pc} !== {2'b10, 1'b1, 32'h0000_5100}) begin $display("FAIL bp_second act=%0h exp=%0h", {bus.out_kind, bus.out_slot, bus.out_pc}, {2'b10, 1'b1, 32'h0000_5100}); n_bad++; end n_cmp++;
        if ({bus.out_target_valid, bus.out_target} !== {1'b1, 32'h1234_5678}) begin $display("FAIL bp_target act=%0h exp=112345678", {bus.out_target_valid, bus.out_target}); n_bad++; end n_cmp++;
        if ({bus.ras_push, bus.ras_pop} !== 2'b00) begin $display("FAIL bp_third_ops act=%0b exp=00", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        tick();
        if ({bus.out_valid, bus.out_kind, bus.out_pc} !== {1'b1, 2'b00, 32'h0000_5200}) begin $display("FAIL bp_third act=%0h exp=%0h", {bus.out_valid, bus.out_kind, bus.out_pc}, {1'b1, 2'b00, 32'h0000_5200}); n_bad++; end n_cmp++;
        tick();
    endtask

    task automatic test_flush();
        bus.ras_ret_pc_pop = 32'h0000_1008;
        bus.out_ready      = 1'b0;
        offer(32'h0000_6000, NOP, JR31, 1'b1);
        tick();
        offer(32'h0000_7000, NOP, JR31, 1'b1);
        tick();
        if (bus.out_valid !== 1'b1) begin $display("FAIL flush_pre_valid act=%0h exp=1", bus.out_valid); n_bad++; end n_cmp++;
        // S and O are full and delay_pending is set; flush with a bundle offered.
        offer(32'h0000_8000, JAL, NOP, 1'b1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        if (bus.ras_flush !== 1'b1) begin $display("FAIL flush_ras_flush act=%0h exp=1", bus.ras_flush); n_bad++; end n_cmp++;
        if ({bus.ras_push, bus.ras_pop} !== 2'b00) begin $display("FAIL flush_ops act=%0b exp=00", {bus.ras_push, bus.ras_pop}); n_bad++; end n_cmp++;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin $display("FAIL flush_after act=%0b exp=01", {bus.out_valid, bus.in_ready}); n_bad++; end n_cmp++;
        if ({bus.ras_push, bus.ras_pop, bus.ras_flush} !== 3'b000) begin $display("FAIL flush_dropped act=%0b exp=000", {bus.ras_push, bus.ras_pop, bus.ras_flush}); n_bad++; end n_cmp++;
        // A cleared delay_pending lets the slot 0 JAL be decoded.
        offer(32'h0000_9000, JAL, NOP, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        if ({bus.ras_push, bus.ras_ret_pc_push} !== {1'b1, 32'h0000_9008}) begin $display("FAIL flush_pend_clear act=%0h exp=100009008", {bus.ras_push, bus.ras_ret_pc_push}); n_bad++; end n_cmp++;
        tick();
        if ({bus.out_valid, bus.out_kind, bus.out_pc} !== {1'b1, 2'b01, 32'h0000_9000}) begin $display("FAIL flush_next_rec act=%0h exp=%0h", {bus.out_valid, bus.out_kind, bus.out_pc}, {1'b1, 2'b01, 32'h0000_9000}); n_bad++; end n_cmp++;
        tick();
    endtask

    initial begin
        n_cmp              = 0;
        n_bad              = 0;
        reset              = 1'b1;
        bus.flush          = 1'b0;
        bus.in_valid       = 1'b0;
        bus.in_pc          = 32'd0;
        bus.in_instr0      = 32'd0;
        bus.in_instr1      = 32'd0;
        bus.in_slot1_valid = 1'b0;
        bus.ras_ret_pc_pop = 32'd0;
        bus.ras_fail       = 1'b0;
        bus.out_ready      = 1'b1;
        test_reset();
        test_call();
        test_return();
        test_ret_fail();
        test_no_op();
        test_jalr_wrap();
        test_back_to_back_stall();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
